// File: rtl/pow2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pow2_pkg : shared types and widths for the pow2_seq power-of-two block.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package pow2_pkg;

   localparam int EXP_W = 3;
   localparam int VAL_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   function automatic logic is_onehot(input logic [VAL_W-1:0] v);
      return (v != '0) && ((v & (v - VAL_W'(1))) == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pow2_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pow2_seq_if : request/result handshake bundle for pow2_seq.              |
// | check_err exists only when POW2_SEQ_CHECK_EN is defined.                 |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface pow2_seq_if;
   import pow2_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [EXP_W-1:0] in_exp;
   logic             out_valid;
   logic             out_ready;
   logic [VAL_W-1:0] out_value;
   logic             busy;
`ifdef POW2_SEQ_CHECK_EN
   logic             check_err;
`endif

   modport master (
      output in_valid,
      output in_exp,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_value,
      input  busy
`ifdef POW2_SEQ_CHECK_EN
      , input check_err
`endif
   );

   modport slave (
      input  in_valid,
      input  in_exp,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_value,
      output busy
`ifdef POW2_SEQ_CHECK_EN
      , output check_err
`endif
   );

endinterface
`default_nettype wire

// File: rtl/pow2_seq_prio_enc8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | prio_enc8 : index of the highest set bit of an 8-bit word, plus a flag   |
// |             that is high when no bit is set.                             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module prio_enc8 (
   input  logic [7:0] din,
   output logic [2:0] idx,
   output logic       zero
);

   always_comb begin
      idx = 3'd0;
      // Ascending scan: the last set bit seen is the most significant one.
      for (int i = 0; i < 8; i++) begin
         if (din[i]) begin
            idx = 3'(i);
         end
      end
   end

   assign zero = (din == 8'h00);

endmodule
`default_nettype wire

// File: rtl/pow2_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pow2_seq : sequential 2**exp generator, one shift per cycle.             |
// | Optional self-check of the result enabled by POW2_SEQ_CHECK_EN.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module pow2_seq
   import pow2_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   pow2_seq_if.slave  bus
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [EXP_W-1:0] r_cnt;
   logic [EXP_W-1:0] w_cnt_nxt;
   logic [EXP_W-1:0] r_exp;
   logic [EXP_W-1:0] w_exp_nxt;
   logic [VAL_W-1:0] r_val;
   logic [VAL_W-1:0] w_val_nxt;
   logic             w_in_ready;
   logic             w_accept;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_exp   <= '0;
         r_val   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_exp   <= w_exp_nxt;
         r_val   <= w_val_nxt;
      end
   end

   // A finishing result may hand its slot straight to the next request.
   assign w_in_ready = (r_state == IDLE) || ((r_state == DONE) && bus.out_ready);
   assign w_accept   = bus.in_valid && w_in_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_exp_nxt   = r_exp;
      w_val_nxt   = r_val;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = SHIFT;
               w_cnt_nxt   = bus.in_exp;
               w_exp_nxt   = bus.in_exp;
               w_val_nxt   = VAL_W'(1);
            end
         end
         SHIFT: begin
            if (r_cnt != '0) begin
               w_val_nxt = r_val << 1;
               w_cnt_nxt = r_cnt - EXP_W'(1);
            end else begin
               w_state_nxt = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  w_state_nxt = SHIFT;
                  w_cnt_nxt   = bus.in_exp;
                  w_exp_nxt   = bus.in_exp;
                  w_val_nxt   = VAL_W'(1);
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == DONE);
   assign bus.out_value = (r_state == DONE) ? r_val : '0;
   assign bus.busy      = (r_state == SHIFT);

`ifdef POW2_SEQ_CHECK_EN
   logic [EXP_W-1:0] w_enc_idx;
   logic             w_enc_zero;

   prio_enc8 u_prio_enc8 (
      .din  (r_val),
      .idx  (w_enc_idx),
      .zero (w_enc_zero)
   );

   assign bus.check_err = (r_state == DONE) &&
                          (w_enc_zero || (w_enc_idx != r_exp) || !is_onehot(r_val));
`else
   // The exponent copy only feeds the checker; keep it referenced in this build.
   logic w_unused_exp;
   assign w_unused_exp = ^r_exp;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pow2_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pow2_seq : vector table, corner sequences and a random run of         |
// |               pow2_seq against a cycle-timing reference model.           |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_pow2_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pow2_seq_if bus ();

   pow2_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a job in flight and the cycle its result shows up.
   int         cyc = 0;
   bit         m_has = 1'b0;
   logic [7:0] m_val = 8'h00;
   int         m_ready_at = 0;

   logic       s_ir, s_ov, s_busy;
   logic [7:0] s_val;
   bit         s_acc, s_done;

   typedef struct {
      logic [2:0] e;
      int         stall;
      logic [7:0] val;
      int         lat;
   } vec_t;

   vec_t tbl [6];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // Compare the current cycle, then advance the model across one clock edge.
   task automatic step();
      bit         ev, eb, eir;
      logic [7:0] evl;
      @(negedge clk);
      ev  = m_has && (cyc >= m_ready_at);
      eb  = m_has && (cyc <  m_ready_at);
      eir = !m_has || (ev && bus.out_ready);
      evl = ev ? m_val : 8'h00;
      s_ir   = bus.in_ready;
      s_ov   = bus.out_valid;
      s_val  = bus.out_value;
      s_busy = bus.busy;
      chk("in_ready",  {7'd0, s_ir},   {7'd0, eir});
      chk("out_valid", {7'd0, s_ov},   {7'd0, ev});
      chk("out_value", s_val,          evl);
      chk("busy",      {7'd0, s_busy}, {7'd0, eb});
`ifdef POW2_SEQ_CHECK_EN
      chk("check_err", {7'd0, bus.check_err}, 8'h00);
`endif
      s_acc  = bus.in_valid && eir && !rst;
      s_done = ev && bus.out_ready && !rst;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_has = 1'b0;
      end else begin
         if (s_done) m_has = 1'b0;
         if (s_acc) begin
            m_has      = 1'b1;
            m_val      = 8'h01 << bus.in_exp;
            m_ready_at = cyc + int'(bus.in_exp) + 1;
         end
      end
      #1;
   endtask

   task automatic wait_result(input int want_lat, input logic [7:0] want_val, input string tag);
      int lat = 0;
      int nb  = 0;
      bit got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (s_ov) begin
            got = 1'b1;
            break;
         end
         lat++;
         if (s_busy) nb++;
      end
      chk({tag, "_seen"},    {7'd0, got}, 8'h01);
      chk({tag, "_latency"}, 8'(lat), 8'(want_lat));
      chk({tag, "_busy_cyc"}, 8'(nb), 8'(want_lat));
      chk({tag, "_value"},   s_val, want_val);
   endtask

   task automatic send(input logic [2:0] e, input string tag);
      bit took = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_exp   = e;
      for (int k = 0; k < 20; k++) begin
         step();
         if (s_acc) begin
            took = 1'b1;
            break;
         end
      end
      chk({tag, "_accept"}, {7'd0, took}, 8'h01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] q_in[$];
      logic [7:0] q_out[$];
      logic [7:0] want;

      tbl[0] = '{3'd0, 0, 8'h01, 1};
      tbl[1] = '{3'd7, 0, 8'h80, 8};
      tbl[2] = '{3'd3, 5, 8'h08, 4};
      tbl[3] = '{3'd5, 2, 8'h20, 6};
      tbl[4] = '{3'd1, 1, 8'h02, 2};
      tbl[5] = '{3'd6, 0, 8'h40, 7};

      bus.in_valid  = 1'b0;
      bus.in_exp    = 3'd0;
      bus.out_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      step();
      step();

      // Table vectors: in_valid stays high with junk exponents during SHIFT.
      for (int v = 0; v < 6; v++) begin
         bus.out_ready = 1'b0;
         send(tbl[v].e, $sformatf("vec%0d", v));
         bus.in_exp = 3'($urandom);
         wait_result(tbl[v].lat, tbl[v].val, $sformatf("vec%0d", v));
         bus.in_valid = 1'b0;
         for (int s = 0; s < tbl[v].stall; s++) begin
            step();
            chk($sformatf("vec%0d_hold", v), s_val, tbl[v].val);
            chk($sformatf("vec%0d_hold_ir", v), {7'd0, s_ir}, 8'h00);
         end
         bus.out_ready = 1'b1;
         step();
         bus.out_ready = 1'b0;
         step();
      end

      // Completion and new acceptance on the same edge.
      bus.out_ready = 1'b0;
      send(3'd2, "b2b_first");
      bus.in_valid = 1'b0;
      wait_result(3, 8'h04, "b2b_first");
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_exp    = 3'd5;
      step();
      chk("b2b_same_edge_acc", {7'd0, s_acc}, 8'h01);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      wait_result(6, 8'h20, "b2b_second");
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
      step();

      // Reset while shifting exponent 6.
      send(3'd6, "rst_mid");
      bus.in_valid = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      chk("rst_mid_ov",  {7'd0, s_ov}, 8'h00);
      chk("rst_mid_val", s_val, 8'h00);
      chk("rst_mid_ir",  {7'd0, s_ir}, 8'h01);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("rst_mid_no_stale", {7'd0, s_ov}, 8'h00);
      end

      // Exhaustive exponents then random ones, streamed with random stalls.
      for (int e = 0; e < 8; e++) q_in.push_back(3'(e));
      for (int e = 0; e < 40; e++) q_in.push_back(3'($urandom));
      for (int k = 0; k < 3000 && (q_in.size() > 0 || q_out.size() > 0); k++) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         if (q_in.size() > 0) begin
            bus.in_valid = 1'b1;
            bus.in_exp   = q_in[0];
         end else begin
            bus.in_valid = 1'b0;
            bus.in_exp   = 3'($urandom);
         end
         step();
         if (s_done && q_out.size() > 0) begin
            want = q_out.pop_front();
            chk("rand_order", s_val, want);
         end
         if (s_acc && q_in.size() > 0) begin
            q_out.push_back(8'h01 << q_in[0]);
            void'(q_in.pop_front());
         end
      end
      chk("rand_drained", 8'(q_in.size() + q_out.size()), 8'h00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pow2_seq.md
POW2_SEQ -- requirements
Module: pow2_seq

Interface
REQ-001 SHALL expose: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL expose: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL expose: in_valid  input  1  upstream offers in_exp.
REQ-004 SHALL expose: in_ready  output  1  block accepts in_exp this cycle.
REQ-005 SHALL expose: in_exp  input  3  exponent, 0..7.
REQ-006 SHALL expose: out_valid  output  1  out_value holds a result.
REQ-007 SHALL expose: out_ready  input  1  downstream takes the result.
REQ-008 SHALL expose: out_value  output  8  one-hot result, 2**in_exp.
REQ-009 SHALL expose: busy  output  1  high in SHIFT state.
REQ-010 SHALL expose, only with POW2_SEQ_CHECK_EN: check_err  output  1  self-check mismatch, valid with out_valid.

Function
REQ-011 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-012 SHALL drive in_ready = (state==IDLE) or (state==DONE and out_ready).
REQ-013 SHALL accept on in_valid and in_ready: latch in_exp into a 3-bit counter and the exponent register; load the value register with 8'h01; enter SHIFT.
REQ-014 SHALL, in SHIFT with counter!=0, shift the value register left by 1 and decrement the counter; with counter==0, enter DONE without shifting.
REQ-015 SHALL assert out_valid exactly in DONE; latency from the accept edge to first out_valid cycle is in_exp+1 cycles (exp 0 -> 1, exp 7 -> 8).
REQ-016 SHALL hold out_value and check_err stable while out_valid and not out_ready.
REQ-017 SHALL, in DONE with out_ready and not in_valid, return to IDLE.
REQ-018 SHALL, in DONE with out_ready and in_valid, complete the old result and accept the new exponent on the same edge (enter SHIFT); no bubble is inserted on input.
REQ-019 SHALL ignore in_valid in SHIFT (in_ready low); in_exp changes there have no effect.
REQ-020 SHALL hold out_value at 8'h00 outside DONE.
REQ-021 SHALL never produce a value wider than 8 bits; exponent 7 yields 8'h80, with no wrap to 8'h01.

Reset
REQ-022 SHALL, on rst high at a clock edge, enter IDLE, clear the counter, exponent and value registers, and force out_valid=0, out_value=8'h00, busy=0, check_err=0; in_ready=1 from the next cycle.
REQ-023 SHALL abort any in-flight SHIFT or pending DONE result on reset, with no output handshake for it.
REQ-024 SHALL give rst priority over every simultaneous handshake.

Configuration
REQ-025 SHALL, with POW2_SEQ_CHECK_EN defined, priority-encode out_value back to 3 bits in DONE and assert check_err when the result differs from the latched exponent or out_value is not one-hot.
REQ-026 SHALL, without POW2_SEQ_CHECK_EN, omit the check_err port and the encoder logic entirely; all other behaviour is identical.

Structure
REQ-027 SHALL place the state enum (IDLE, SHIFT, DONE), EXP_W=3 and VAL_W=8 in shared package pow2_pkg.
REQ-028 SHALL implement the REQ-025 check as sub-module prio_enc8 (8-bit in, 3-bit index of highest set bit, plus zero flag), instantiated only under POW2_SEQ_CHECK_EN.

Verification
REQ-029 SHALL cover: in_exp=0 accepted, out_ready=1 -> out_value=8'h01, out_valid 1 cycle after accept, check_err=0.
REQ-030 SHALL cover: in_exp=7 accepted -> out_value=8'h80 after 8 cycles; busy high for exactly 8 cycles.
REQ-031 SHALL cover: in_exp=3, out_ready low for 5 cycles -> out_value=8'h08 held stable, in_ready low until out_ready rises.
REQ-032 SHALL cover: DONE with out_ready=1, in_valid=1, in_exp=5 on the same cycle -> old result consumed, new result 8'h20 appears 6 cycles later.
REQ-033 SHALL cover: rst pulsed mid-SHIFT for in_exp=6 -> next cycle out_valid=0, out_value=8'h00, in_ready=1; no stale result appears.
REQ-034 SHALL cover: exhaustive in_exp 0..7 back-to-back with random out_ready stalls -> out_value = 1<<in_exp in order, check_err never set.
